oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have the following ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_en  in  1  one-clk strobe per CPU M-cycle; all state advances only on clk edges where cpu_en=1
- start  in  1  FF46 write strobe (already suppressed by the register block for values E0-FF)
- start_addr  in  8  source page high byte, valid with start
- src_addr  out  16  source read address
- src_rd  out  1  source read request
- src_rdata  in  8  source read data, valid by the next cpu_en edge after src_addr is presented
- oam_addr  out  8  OAM write index 0x00-0x9F
- oam_wdata  out  8  OAM write data
- oam_write  out  1  OAM write strobe, one clk wide
- busy  out  1  transfer pending or in progress
- bus_block  out  1  CPU external bus / OAM blocked

Function
REQ-003 The block SHALL implement exactly three states: IDLE, START and XFER.
REQ-004 An edge with start=1 and cpu_en=1 SHALL latch start_addr into base, clear idx (8 bits) to 0 and enter START, from any state.
REQ-005 On an edge with cpu_en=1 in START and no new start, the block SHALL enter XFER; this gives exactly one M-cycle of startup delay.
REQ-006 In XFER the block SHALL drive src_addr={base, idx} and src_rd=1 continuously.
REQ-007 In all other states the block SHALL drive src_rd=0 and src_addr=16'h0.
REQ-008 Each edge with cpu_en=1 in XFER and no new start SHALL perform all of the following:
- register oam_wdata<=src_rdata and oam_addr<=idx
- set oam_write=1 for exactly the following clk cycle
- increment idx
REQ-009 When idx=159 (0x9F) is written, the block SHALL enter IDLE instead of incrementing; idx SHALL never exceed 159.
REQ-010 A transfer SHALL consist of exactly 160 OAM writes with oam_addr 0x00..0x9F in order, one per M-cycle.
REQ-011 oam_write SHALL be 0 whenever no XFER step occurred on the previous edge; it SHALL never be high for two consecutive clk cycles unless cpu_en is high on consecutive edges.
REQ-012 busy SHALL be high in START and XFER.
REQ-013 bus_block SHALL be high in XFER, and also in START when START was entered from XFER (restart).
REQ-014 A restart during XFER SHALL abort the old transfer without completing it; the old transfer SHALL perform no further OAM writes after the restart edge.
REQ-015 A start on the same edge as the final (idx=159) write SHALL take priority: the block SHALL enter START, and the final write SHALL NOT be issued.
REQ-016 start with cpu_en=0 SHALL be ignored.
REQ-017 Edges with cpu_en=0 SHALL hold all state and outputs, except that oam_write returns to 0 after its single cycle.

Reset
REQ-018 Asserting reset SHALL immediately force all of the following, independent of clk: state=IDLE, idx=0, base=0, oam_addr=0, oam_wdata=0, oam_write=0, busy=0, bus_block=0, src_rd=0, src_addr=0.
REQ-019 A reset asserted during XFER SHALL abort the transfer with no further OAM writes.
REQ-020 After reset deasserts, the block SHALL remain in IDLE until a qualified start.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- start_addr=0xC1, cpu_en every 4 clks, src model returns low byte of address -> 160 writes, oam_addr n gets data n, first write at M-cycle 2 after start, busy falls after M-cycle 161.
- start during XFER at idx=0x50 with start_addr=0x80 -> no write for old idx 0x50, one M-cycle gap with bus_block=1, then 160 writes from 0x8000.
- start coincident with the idx=0x9F step -> no write to 0x9F from the old transfer, new transfer starts at 0x00.
- start with cpu_en=0 -> state stays IDLE, busy=0.
- reset asserted mid-XFER between clk edges -> outputs zero immediately, no writes afterward, next start behaves as the first scenario.
- cpu_en held high every clk -> 160 consecutive oam_write cycles, src_addr stepping 0xC100..0xC19F.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from page {base,00} into OAM, one byte per
// CPU M-cycle, after one M-cycle of startup delay. A new start restarts the
// transfer from any state, and an in-flight transfer is abandoned.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        start,
  input  logic [7:0]  start_addr,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_write,
  output logic        busy,
  output logic        bus_block
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'd159;

  state_e      state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  idx_q, idx_d;
  logic        restart_q, restart_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_wdata_q, oam_wdata_d;
  logic        oam_write_q, oam_write_d;
  logic        busy_q, busy_d;
  logic        bus_block_q, bus_block_d;
  logic        src_rd_q, src_rd_d;
  logic [15:0] src_addr_q, src_addr_d;

  // Next-state logic: everything advances only on M-cycle edges, except the
  // write strobe which always falls back to 0 one clk after it was raised.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    restart_d   = restart_q;
    oam_addr_d  = oam_addr_q;
    oam_wdata_d = oam_wdata_q;
    oam_write_d = 1'b0;
    if (cpu_en) begin
      if (start) begin
        // A new start wins over any step of an older transfer.
        state_d   = START;
        base_d    = start_addr;
        idx_d     = 8'd0;
        restart_d = (state_q == XFER);
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          START: begin
            state_d = XFER;
          end
          XFER: begin
            oam_wdata_d = src_rdata;
            oam_addr_d  = idx_q;
            oam_write_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    // Status and source-bus outputs are registered from the next state so
    // they line up with the state register itself.
    busy_d      = (state_d != IDLE);
    bus_block_d = (state_d == XFER) || ((state_d == START) && restart_d);
    src_rd_d    = (state_d == XFER);
    if (state_d == XFER) begin
      src_addr_d = {base_d, idx_d};
    end else begin
      src_addr_d = 16'h0000;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= 8'd0;
      idx_q       <= 8'd0;
      restart_q   <= 1'b0;
      oam_addr_q  <= 8'd0;
      oam_wdata_q <= 8'd0;
      oam_write_q <= 1'b0;
      busy_q      <= 1'b0;
      bus_block_q <= 1'b0;
      src_rd_q    <= 1'b0;
      src_addr_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      restart_q   <= restart_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
      oam_write_q <= oam_write_d;
      busy_q      <= busy_d;
      bus_block_q <= bus_block_d;
      src_rd_q    <= src_rd_d;
      src_addr_q  <= src_addr_d;
    end
  end

  assign src_addr  = src_addr_q;
  assign src_rd    = src_rd_q;
  assign oam_addr  = oam_addr_q;
  assign oam_wdata = oam_wdata_q;
  assign oam_write = oam_write_q;
  assign busy      = busy_q;
  assign bus_block = bus_block_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma.
module tb_oam_dma;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic        start;
  logic [7:0]  start_addr;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;
  logic        busy;
  logic        bus_block;

  int n_checks = 0;
  int n_fail   = 0;

  // Source memory model: low address byte, optionally mixed with the page
  // byte and a key so data cannot be confused with the OAM index.
  logic [7:0] key;
  logic       mix;
  assign src_rdata = src_rd ? (src_addr[7:0] ^ key ^ (mix ? src_addr[15:8] : 8'h00)) : 8'hEE;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .start      (start),
    .start_addr (start_addr),
    .src_addr   (src_addr),
    .src_rd     (src_rd),
    .src_rdata  (src_rdata),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_write  (oam_write),
    .busy       (busy),
    .bus_block  (bus_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logger: one entry per clk cycle with oam_write high, plus the
  // longest run of consecutive write cycles.
  logic [15:0] wr_q[$];
  int run_len = 0;
  int max_run = 0;
  always @(negedge clk) begin
    if (oam_write === 1'b1) begin
      wr_q.push_back({oam_addr, oam_wdata});
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One M-cycle: cpu_en high for one clk edge, then gap-1 idle edges.
  // Returns just after the following falling edge.
  task automatic mcycle(input int gap, input logic st, input logic [7:0] sa);
    cpu_en = 1'b1;
    start = st;
    start_addr = sa;
    @(posedge clk);
    #1;
    cpu_en = 1'b0;
    start = 1'b0;
    repeat (gap - 1) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Compare the logged writes against a full 0x00..0x9F transfer.
  task automatic check_xfer(input string tag, input logic [7:0] hi);
    int bad;
    logic [7:0] n;
    logic [15:0] e;
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      n = i[7:0];
      e = {n, n ^ key ^ (mix ? hi : 8'h00)};
      if (i >= 160 || wr_q[i] !== e) bad++;
    end
    chk({tag, "_count"}, wr_q.size(), 32'd160);
    chk({tag, "_bad_entries"}, bad, 32'd0);
  endtask

  logic [15:0] first;
  int bad_addr;

  initial begin
    reset = 1'b1;
    cpu_en = 1'b0;
    start = 1'b0;
    start_addr = 8'h00;
    key = 8'h00;
    mix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 32'd0);
    chk("rst_bus_block", bus_block, 32'd0);
    chk("rst_src", {src_rd, src_addr}, 32'd0);
    chk("rst_oam", {oam_write, oam_addr, oam_wdata}, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    mcycle(4, 1'b0, 8'h00);
    chk("idle_after_reset", busy, 32'd0);

    // Scenario 1: C1 page, cpu_en every 4 clks, data = low address byte.
    mcycle(4, 1'b1, 8'hC1);
    chk("s1_start_busy", busy, 32'd1);
    chk("s1_start_bus_block", bus_block, 32'd0);
    chk("s1_start_src", {src_rd, src_addr}, 32'd0);
    mcycle(4, 1'b0, 8'h00);
    chk("s1_xfer_src", {src_rd, src_addr}, {15'd0, 1'b1, 16'hC100});
    chk("s1_xfer_bus_block", bus_block, 32'd1);
    chk("s1_no_write_yet", wr_q.size(), 32'd0);
    wr_q.delete();
    max_run = 0;
    mcycle(4, 1'b0, 8'h00);
    first = (wr_q.size() > 0) ? wr_q[0] : 16'hFFFF;
    chk("s1_first_write_count", wr_q.size(), 32'd1);
    chk("s1_first_write", first, 32'h0000);
    for (int i = 1; i < 160; i++) begin
      mcycle(4, 1'b0, 8'h00);
      if (i == 158) chk("s1_busy_before_last", busy, 32'd1);
    end
    check_xfer("s1", 8'hC1);
    chk("s1_busy_done", busy, 32'd0);
    chk("s1_bus_block_done", bus_block, 32'd0);
    chk("s1_src_done", {src_rd, src_addr}, 32'd0);
    chk("s1_single_pulse", max_run, 32'd1);

    // Scenario 2: restart at idx 0x50 onto page 0x80.
    key = 8'h5A;
    mcycle(4, 1'b1, 8'hC1);
    mcycle(4, 1'b0, 8'h00);
    repeat (8'h50) mcycle(4, 1'b0, 8'h00);
    chk("s2_src_before_restart", src_addr, 32'hC150);
    wr_q.delete();
    mcycle(4, 1'b1, 8'h80);
    chk("s2_restart_no_write", wr_q.size(), 32'd0);
    chk("s2_restart_busy", busy, 32'd1);
    chk("s2_restart_bus_block", bus_block, 32'd1);
    chk("s2_restart_src_rd", src_rd, 32'd0);
    mcycle(4, 1'b0, 8'h00);
    chk("s2_gap_no_write", wr_q.size(), 32'd0);
    chk("s2_new_src", src_addr, 32'h8000);
    repeat (160) mcycle(4, 1'b0, 8'h00);
    check_xfer("s2", 8'h80);
    chk("s2_busy_done", busy, 32'd0);

    // Scenario 3: start on the same edge as the idx=0x9F step.
    mcycle(2, 1'b1, 8'hC1);
    mcycle(2, 1'b0, 8'h00);
    repeat (159) mcycle(2, 1'b0, 8'h00);
    chk("s3_src_last", src_addr, 32'hC19F);
    wr_q.delete();
    mcycle(2, 1'b1, 8'hC2);
    chk("s3_no_final_write", wr_q.size(), 32'd0);
    chk("s3_restart_bus_block", bus_block, 32'd1);
    mcycle(2, 1'b0, 8'h00);
    chk("s3_new_src", src_addr, 32'hC200);
    mcycle(1, 1'b0, 8'h00);
    first = (wr_q.size() > 0) ? wr_q[0] : 16'hFFFF;
    chk("s3_first_new_write", {wr_q.size(), first}, {16'd1, 16'h005A});

    // Scenario 5: reset mid-transfer, between clock edges, while a write is high.
    chk("s5_write_high_before", oam_write, 32'd1);
    reset = 1'b1;
    #1;
    chk("s5_rst_oam", {oam_write, oam_addr, oam_wdata}, 32'd0);
    chk("s5_rst_src", {src_rd, src_addr}, 32'd0);
    chk("s5_rst_status", {busy, bus_block}, 32'd0);
    wr_q.delete();
    repeat (3) mcycle(1, 1'b0, 8'h00);
    reset = 1'b0;
    repeat (3) mcycle(1, 1'b0, 8'h00);
    chk("s5_no_writes", wr_q.size(), 32'd0);
    chk("s5_idle", busy, 32'd0);

    // Scenario 4: start with cpu_en low is ignored.
    start = 1'b1;
    start_addr = 8'hC5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("s4_ignored_busy", busy, 32'd0);
    mcycle(1, 1'b0, 8'h00);
    mcycle(1, 1'b0, 8'h00);
    chk("s4_still_idle", {busy, src_rd, src_addr}, 32'd0);

    // Scenario 6: cpu_en every clk, data mixes page byte in.
    key = 8'h00;
    mix = 1'b1;
    mcycle(1, 1'b1, 8'hC1);
    mcycle(1, 1'b0, 8'h00);
    chk("s6_src_first", src_addr, 32'hC100);
    wr_q.delete();
    max_run = 0;
    bad_addr = 0;
    for (int i = 0; i < 160; i++) begin
      if (src_addr !== (16'hC100 + i[15:0])) bad_addr++;
      mcycle(1, 1'b0, 8'h00);
    end
    chk("s6_src_steps", bad_addr, 32'd0);
    check_xfer("s6", 8'hC1);
    chk("s6_consecutive", max_run, 32'd160);
    chk("s6_busy_done", busy, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
